// File: rtl/param_address_register.sv
// Parametrised RAM address register: bus load, synchronised front-panel load,
// optional auto-increment enabled by defining PAR_AUTO_INC_EN.
module param_address_register #(
   parameter int ADDR_W      = 4,
   parameter int BUS_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              read_from_bus,
   input  logic              inc,
   input  logic              manual_mode,
   input  logic              manual_read,
   input  logic [ADDR_W-1:0] manual_switches,
   input  logic [BUS_W-1:0]  bus,
   output logic [ADDR_W-1:0] address,
   output logic              manual_ack,
   output logic              wrapped
);

   if (ADDR_W < 1 || ADDR_W > 16) begin : g_bad_addr_w
      $error("ADDR_W must be in 1..16");
   end
   if (BUS_W < ADDR_W) begin : g_bad_bus_w
      $error("BUS_W must be >= ADDR_W");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("SYNC_STAGES must be in 2..4");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   load_pulse;

   logic [ADDR_W-1:0] address_q;
   logic [ADDR_W-1:0] addr_d;
   logic              ack_q;
   logic              ack_d;
   logic              wrap_d;

   logic              sel_manual;
   logic              sel_bus;
   logic              sel_inc;
   logic [ADDR_W-1:0] addr_inc;
   logic              inc_wraps;

   // Reset to all-ones so a button held through reset never looks like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         hist_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], manual_read};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign load_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

   assign sel_manual = load_pulse & manual_mode;
   assign sel_bus    = read_from_bus & ~manual_mode;

`ifdef PAR_AUTO_INC_EN
   assign sel_inc   = inc & ~manual_mode & ~read_from_bus;
   assign addr_inc  = address_q + ADDR_W'(1);
   assign inc_wraps = &address_q;
`else
   assign sel_inc   = 1'b0;
   assign addr_inc  = address_q;
   assign inc_wraps = 1'b0;
`endif

   always_comb begin
      addr_d = address_q;
      ack_d  = 1'b0;
      wrap_d = 1'b0;
      unique case (1'b1)
         sel_manual: begin
            addr_d = manual_switches;
            ack_d  = 1'b1;
         end
         sel_bus: begin
            addr_d = bus[ADDR_W-1:0];
         end
         sel_inc: begin
            addr_d = addr_inc;
            wrap_d = inc_wraps;
         end
         default: begin
            addr_d = address_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         address_q <= '0;
         ack_q     <= 1'b0;
      end else begin
         address_q <= addr_d;
         ack_q     <= ack_d;
      end
   end

`ifdef PAR_AUTO_INC_EN
   logic wrap_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   assign wrapped = wrap_q;
`else
   assign wrapped = 1'b0;
`endif

   // Upper bus bits and, in the fixed build, inc are intentionally dropped.
   logic unused_bits;
   assign unused_bits = ^{bus, inc, wrap_d};

   assign address    = address_q;
   assign manual_ack = ack_q;

endmodule

// File: tb/tb_param_address_register.sv
// Self-checking bench for param_address_register: event-level model,
// per-cycle compare process, directed literal pins and random traffic.
module tb_param_address_register;

   localparam int A = 4;
   localparam int B = 8;
   localparam int S = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         read_from_bus;
   logic         inc;
   logic         manual_mode;
   logic         manual_read;
   logic [A-1:0] manual_switches;
   logic [B-1:0] bus;
   logic [A-1:0] address;
   logic         manual_ack;
   logic         wrapped;

   param_address_register #(
      .ADDR_W(A),
      .BUS_W(B),
      .SYNC_STAGES(S)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .read_from_bus(read_from_bus),
      .inc(inc),
      .manual_mode(manual_mode),
      .manual_read(manual_read),
      .manual_switches(manual_switches),
      .bus(bus),
      .address(address),
      .manual_ack(manual_ack),
      .wrapped(wrapped)
   );

   always #5 clk = ~clk;

`ifdef PAR_AUTO_INC_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   // Model: a press is a sampled 0->1 of the button; its load is due
   // exactly S edges later and fires only if manual mode is on then.
   int m_addr = 0;
   int m_ack  = 0;
   int m_wrap = 0;
   int edge_n = 0;
   int prev_s = 1;
   int due_q[$];

   task automatic model_reset();
      m_addr = 0;
      m_ack  = 0;
      m_wrap = 0;
      edge_n = 0;
      prev_s = 1;
      due_q.delete();
   endtask

   task automatic model_step();
      int pulse;
      pulse = 0;
      if (due_q.size() > 0 && due_q[0] == edge_n) begin
         pulse = 1;
         void'(due_q.pop_front());
      end
      m_ack  = 0;
      m_wrap = 0;
      if (pulse == 1 && manual_mode) begin
         m_addr = int'(manual_switches);
         m_ack  = 1;
      end else if (!manual_mode && read_from_bus) begin
         m_addr = int'(bus) % (1 << A);
      end else if (AUTO && !manual_mode && inc) begin
         m_wrap = (m_addr == (1 << A) - 1) ? 1 : 0;
         m_addr = (m_addr + 1) % (1 << A);
      end
      if (manual_read && prev_s == 0) due_q.push_back(edge_n + S);
      prev_s = manual_read ? 1 : 0;
      edge_n = edge_n + 1;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else model_step();
   end

   int checks   = 0;
   int failures = 0;
   int lit_req  = 0;
   int lit_done = 0;
   int lit_a    = 0;
   int lit_k    = 0;
   int lit_w    = 0;

   task automatic chk(string nm, int got, int exp);
      checks = checks + 1;
      if (got != exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("address", int'(address), m_addr);
      chk("manual_ack", int'(manual_ack), m_ack);
      chk("wrapped", int'(wrapped), m_wrap);
      if (lit_req != lit_done) begin
         chk("lit_address", int'(address), lit_a);
         chk("lit_ack", int'(manual_ack), lit_k);
         chk("lit_wrapped", int'(wrapped), lit_w);
         chk("model_pin", m_addr, lit_a);
         lit_done = lit_req;
      end
   end

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic expect_lit(int a, int k, int w);
      lit_a   = a;
      lit_k   = k;
      lit_w   = w;
      lit_req = lit_req + 1;
   endtask

   initial begin
      rst_n           = 1'b0;
      read_from_bus   = 1'b0;
      inc             = 1'b0;
      manual_mode     = 1'b0;
      manual_read     = 1'b0;
      manual_switches = '0;
      bus             = '0;
      tick(2);
      expect_lit(0, 0, 0);
      tick(1);
      rst_n = 1'b1;
      tick(2);

      // Bus load keeps only the low address bits
      bus           = 8'hA7;
      read_from_bus = 1'b1;
      tick(1);
      read_from_bus = 1'b0;
      expect_lit(7, 0, 0);
      tick(1);

      // Reset mid-run
      rst_n = 1'b0;
      tick(1);
      expect_lit(0, 0, 0);
      rst_n = 1'b1;
      bus           = 8'hA7;
      read_from_bus = 1'b1;
      tick(1);
      read_from_bus = 1'b0;
      expect_lit(7, 0, 0);
      tick(1);

      // Front-panel load lands S edges after first sample, held button is one load
      manual_mode     = 1'b1;
      manual_switches = 4'hC;
      manual_read     = 1'b1;
      tick(1);
      expect_lit(7, 0, 0);
      tick(1);
      expect_lit(7, 0, 0);
      tick(1);
      expect_lit(12, 1, 0);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         expect_lit(12, 0, 0);
      end
      manual_read = 1'b0;
      tick(3);

      // Bus and inc ignored in manual mode
      bus           = 8'h05;
      read_from_bus = 1'b1;
      inc           = 1'b1;
      tick(1);
      read_from_bus = 1'b0;
      inc           = 1'b0;
      expect_lit(12, 0, 0);
      tick(1);

      // Press in run mode is discarded, not queued
      manual_mode     = 1'b0;
      manual_switches = 4'h3;
      manual_read     = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         expect_lit(12, 0, 0);
      end
      manual_mode = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         expect_lit(12, 0, 0);
      end
      manual_read = 1'b0;
      manual_mode = 1'b0;
      tick(3);

`ifdef PAR_AUTO_INC_EN
      bus           = 8'h0E;
      read_from_bus = 1'b1;
      tick(1);
      read_from_bus = 1'b0;
      expect_lit(14, 0, 0);
      inc = 1'b1;
      tick(1);
      expect_lit(15, 0, 0);
      tick(1);
      expect_lit(0, 0, 1);
      tick(1);
      expect_lit(1, 0, 0);
      bus           = 8'h03;
      read_from_bus = 1'b1;
      tick(1);
      expect_lit(3, 0, 0);
      read_from_bus = 1'b0;
      inc           = 1'b0;
      tick(1);
      expect_lit(3, 0, 0);
`else
      bus           = 8'h0F;
      read_from_bus = 1'b1;
      tick(1);
      read_from_bus = 1'b0;
      expect_lit(15, 0, 0);
      inc = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         expect_lit(15, 0, 0);
      end
      inc = 1'b0;
`endif
      tick(1);

      // Button held across reset release gives no load
      manual_mode     = 1'b1;
      manual_switches = 4'h5;
      manual_read     = 1'b1;
      rst_n           = 1'b0;
      tick(2);
      expect_lit(0, 0, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         expect_lit(0, 0, 0);
      end
      manual_read = 1'b0;
      tick(2);
      manual_read = 1'b1;
      tick(1);
      expect_lit(0, 0, 0);
      tick(1);
      expect_lit(0, 0, 0);
      tick(1);
      expect_lit(5, 1, 0);
      manual_read = 1'b0;
      tick(1);
      expect_lit(5, 0, 0);
      tick(2);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) manual_mode = ~manual_mode;
         if ($urandom_range(0, 3) == 0) manual_read = ~manual_read;
         read_from_bus   = ($urandom_range(0, 3) == 0);
         inc             = ($urandom_range(0, 2) != 0);
         bus             = B'($urandom);
         manual_switches = A'($urandom);
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
         tick(1);
      end
      rst_n = 1'b1;
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/param_address_register.md
# param_address_register

Parametrised memory address register for the 8-bit CPU. It holds the RAM address and loads it from the bus, from a synchronised front-panel switch load, or from an optional auto-increment. The front-panel load is driven by a properly synchronised, edge-detected pushbutton rather than by a clock, and all widths are parameters. It sits between the shared bus and the RAM address input and replaces the fixed 4-bit register.

## Interface
- ADDR_W, default 4: address width; valid range 1..16.
- BUS_W, default 8: bus width; must satisfy BUS_W >= ADDR_W. Elaboration fails otherwise.
- SYNC_STAGES, default 2: synchroniser depth for `manual_read`; valid range 2..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- read_from_bus  in  1  load the address from the bus (run mode only).
- inc  in  1  increment the address by 1 (run mode only; see Configuration).
- manual_mode  in  1  1 selects front-panel mode; 0 selects run mode.
- manual_read  in  1  raw, asynchronous front-panel load button.
- manual_switches  in  ADDR_W  front-panel address value.
- bus  in  BUS_W  shared data bus.
- address  out  ADDR_W  registered RAM address.
- manual_ack  out  1  one-cycle pulse, coincident with a front-panel load.
- wrapped  out  1  one-cycle pulse after an increment from all-ones to 0.

## Operation
- `manual_read` passes through a chain of SYNC_STAGES flops. The last stage feeds a history flop.
- `load_pulse` = last stage AND NOT history. It is therefore exactly one cycle wide per button press.
- Register priority on each rising edge, highest first:
  1. `load_pulse && manual_mode`: address <= manual_switches; manual_ack <= 1.
  2. `read_from_bus && !manual_mode`: address <= bus[ADDR_W-1:0]; the upper bus bits are ignored.
  3. `inc && !manual_mode`: address <= address + 1, modulo 2^ADDR_W. wrapped <= 1 if the old address was all-ones.
  4. Otherwise: hold. manual_ack and wrapped return to 0.
- If `read_from_bus` and `inc` are asserted together, the bus load wins and there is no increment.
- In manual mode, `read_from_bus` and `inc` are ignored.
- A `load_pulse` that occurs while `manual_mode` is 0 is discarded. It is not queued.
- `manual_mode` is not synchronised. It is a level control and is qualified in the same cycle it is sampled.
- Holding the button does not repeat the load. The button must go low for at least one synchronised sample before the next load.

## Timing
- Reset (rst_n low, asynchronous): address = 0, manual_ack = 0, wrapped = 0.
- Also on reset, every synchroniser and history flop is set to 1. A button held across reset release therefore produces no load.
- Reset release takes effect at the first rising edge with rst_n high. Reset asserted mid-press cancels the press.
- Bus load and increment: address is updated at the rising edge where the control is sampled high. Latency is 1 cycle.
- Front-panel load: `manual_read` is first sampled high at edge 0.
  - address and manual_ack update at edge SYNC_STAGES (edge 2 by default).
  - manual_ack stays high for exactly one cycle.
- `manual_switches` is sampled at the load edge only. The bench must hold it stable for SYNC_STAGES+1 cycles after the press.
- wrapped is high for exactly the one cycle following the wrapping edge.

## Configuration
- Macro: `PAR_AUTO_INC_EN`.
- Defined: `inc` is functional and `wrapped` operates as described above.
- Undefined:
  - The increment logic is not compiled.
  - `inc` is ignored, and `wrapped` is tied to 0.
  - The priority list drops item 3.
  - The port list is identical in both builds.

## Test plan
- Reset and bus load: hold rst_n low mid-run, then release. Expect address = 0. Then set bus = 8'hA7 and read_from_bus = 1 for one cycle. Expect address = 4'h7 one edge later.
- Manual load latency: manual_mode = 1, manual_switches = 4'hC, raise manual_read. Expect address = 4'hC and manual_ack high for one cycle at edge 2. Holding the button for 10 cycles must produce no further ack.
- Mode gating: in manual mode, pulse read_from_bus with bus = 8'h05 and pulse inc. Expect address unchanged. In run mode, press the button. Expect no load and no ack, and no load after switching back to manual without a new press.
- Increment and wrap (macro defined): load 4'hE, then assert inc for 3 cycles. Expect F, 0, 1, with wrapped high only in the cycle after the F->0 edge. Assert read_from_bus and inc together with bus = 8'h03. Expect 3.
- Macro undefined: assert inc for 5 cycles from address 4'hF. Expect address to stay 4'hF and wrapped to stay 0.
- Reset across press: hold manual_read high during reset, then release reset with the button still held. Expect no load. Release the button and press again. Expect a load at edge 2.
